alu_seq: RTL

Parametrised, handshaked successor to the team's combinational add/sub/multiply ALU.
- Add and subtract are single-cycle and registered.
- Multiply is an iterative shift-add unit that uses one adder instead of a combinational multiplier array.
- Operands and results flow through valid/ready handshakes, so the block sits between an operand source (register file or sequencer) and a result sink that may stall.
- Adds an overflow flag, a busy indicator and backpressure-safe result holding.

---
 rtl/alu_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked add/sub ALU with an iterative shift-add multiplier.
// Results are held in registers until the sink accepts them.
module alu_seq #(
    parameter int PART_LEN   = 8,
    parameter int MUL_SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*PART_LEN-1:0]   a,
    input  logic [2*PART_LEN-1:0]   b,
    input  logic [1:0]              control_sig,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*PART_LEN-1:0]   res,
    output logic                    ovf,
    output logic                    busy
);
    localparam int W   = 2 * PART_LEN;
    localparam int CW  = $clog2(W);
    localparam bit SGN = (MUL_SIGNED != 0);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    res_q, mcand_q, mplier_q;
    logic [2*W-1:0]  acc_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q, vld_q, neg_q;

    logic [W:0]      sum_w, dif_w;
    logic [W-1:0]    mag_a, mag_b;
    logic [2*W-1:0]  acc_d, prod;
    logic            mul_ovf;

    // Signed multiply iterates on magnitudes; the W-bit magnitude of the most negative value is exact.
    always_comb begin
        sum_w   = {1'b0, a} + {1'b0, b};
        dif_w   = {1'b0, a} - {1'b0, b};
        mag_a   = (SGN && a[W-1]) ? -a : a;
        mag_b   = (SGN && b[W-1]) ? -b : b;
        acc_d   = acc_q + (mplier_q[0] ? ({{W{1'b0}}, mcand_q} << cnt_q) : '0);
        prod    = (SGN && neg_q) ? -acc_d : acc_d;
        mul_ovf = SGN ? (prod[2*W-1:W] != {W{prod[W-1]}}) : |prod[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    if (control_sig[1]) begin
                        res_q   <= control_sig[0] ? dif_w[W-1:0] : sum_w[W-1:0];
                        ovf_q   <= control_sig[0] ? dif_w[W] : sum_w[W];
                        vld_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        mcand_q  <= mag_a;
                        mplier_q <= mag_b;
                        neg_q    <= SGN && (a[W-1] ^ b[W-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        res_q   <= prod[W-1:0];
                        ovf_q   <= mul_ovf;
                        vld_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    vld_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = vld_q;
    assign res       = res_q;
    assign ovf       = ovf_q;
endmodule
